// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings and decode helpers for the ALU control block
package alu_pkg;

  // ALU operation select values
  localparam logic [3:0] OP_AND    = 4'h0;
  localparam logic [3:0] OP_OR     = 4'h1;
  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_SUB    = 4'h6;
  localparam logic [3:0] OP_SLT    = 4'h7;
  localparam logic [3:0] OP_SLL    = 4'h8;
  localparam logic [3:0] OP_SRL    = 4'h9;
  localparam logic [3:0] OP_SRA    = 4'hA;
  localparam logic [3:0] OP_NOR    = 4'hC;
  localparam logic [3:0] OP_MULDIV = 4'hF;

  // Main-control instruction classes
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_ANDI  = 3'b011;
  localparam logic [2:0] ALUOP_ORI   = 3'b100;
  localparam logic [2:0] ALUOP_SLTI  = 3'b101;
  localparam logic [2:0] ALUOP_XORI  = 3'b110;
  localparam logic [2:0] ALUOP_AND   = 3'b111;

  // R-type function codes
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  // mult/multu/div/divu occupy 0110xx; bit 1 selects divide, bit 0 selects unsigned
  function automatic logic is_muldiv(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

  function automatic logic [3:0] decode_op(input logic [2:0] aluop, input logic [5:0] f);
    logic [3:0] op;
    op = OP_AND;
    case (aluop)
      ALUOP_ADD:  op = OP_ADD;
      ALUOP_SUB:  op = OP_SUB;
      ALUOP_ANDI: op = OP_AND;
      ALUOP_ORI:  op = OP_OR;
      ALUOP_SLTI: op = OP_SLT;
      ALUOP_XORI: op = OP_XOR;
      ALUOP_AND:  op = OP_AND;
      ALUOP_RTYPE: begin
        case (f)
          F_ADD, F_ADDU:                 op = OP_ADD;
          F_SUB, F_SUBU:                 op = OP_SUB;
          F_AND:                         op = OP_AND;
          F_OR:                          op = OP_OR;
          F_XOR:                         op = OP_XOR;
          F_NOR:                         op = OP_NOR;
          F_SLT:                         op = OP_SLT;
          F_SLL:                         op = OP_SLL;
          F_SRL:                         op = OP_SRL;
          F_SRA:                         op = OP_SRA;
          F_MULT, F_MULTU, F_DIV, F_DIVU: op = OP_MULDIV;
          default:                       op = OP_AND;
        endcase
      end
      default: op = OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one-bit-per-cycle unsigned shift-add multiply / restoring divide
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 div_mode,
  input  logic                 step,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 last,
  output logic [2*WIDTH-1:0]   acc
);

  localparam int CW = $clog2(WIDTH + 1);

  // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div
  logic [CW-1:0]      count;
  logic               mode_div;
  logic [WIDTH-1:0]   operand_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     sub_diff;
  logic [2*WIDTH-1:0] acc_next;

  assign last = (count == CW'(1));

  // single iteration: conditional add then shift right, or shift left then trial subtract
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand_b};
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    sub_diff = shifted - {1'b0, operand_b};
    acc_next = acc;
    if (mode_div) begin
      if (!sub_diff[WIDTH])
        acc_next = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0])
        acc_next = {add_sum, acc[WIDTH-1:1]};
      else
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  // operand load and per-cycle iteration with countdown
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      mode_div  <= 1'b0;
      operand_b <= '0;
      acc       <= '0;
    end else if (load) begin
      count     <= CW'(WIDTH);
      mode_div  <= div_mode;
      operand_b <= op_b;
      acc       <= {{WIDTH{1'b0}}, op_a};
    end else if (step && count != '0) begin
      acc   <= acc_next;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_control_mc.sv
// rtl/alu_control_mc.sv - ALU control decode with iterative mul/div engine and HI/LO
module alu_control_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUop,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [OPW-1:0]   operation,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state;
  logic               launch;
  logic               div_zero;
  logic               signed_op;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               is_div_q;
  logic               neg_res;
  logic               neg_rem;
  logic               eng_last;
  logic [2*WIDTH-1:0] eng_acc;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign operation = OPW'(decode_op(ALUop, func));

  // launch qualification and operand magnitudes; unsigned ops pass operands raw
  always_comb begin
    launch    = start && (ALUop == ALUOP_RTYPE) && is_muldiv(func) &&
                (state == S_IDLE || state == S_DONE);
    div_zero  = func[1] && (b == '0);
    signed_op = !func[0];
    sign_a    = signed_op && a[WIDTH-1];
    sign_b    = signed_op && b[WIDTH-1];
    mag_a     = sign_a ? -a : a;
    mag_b     = sign_b ? -b : b;
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_engine (
    .clk      (clk),
    .reset    (reset),
    .load     (launch && !div_zero),
    .div_mode (func[1]),
    .step     (state == S_RUN),
    .op_a     (mag_a),
    .op_b     (mag_b),
    .last     (eng_last),
    .acc      (eng_acc)
  );

  // sign correction of the magnitude result; remainder follows the dividend's sign
  always_comb begin
    if (is_div_q) begin
      fix_lo = neg_res ? -eng_acc[WIDTH-1:0] : eng_acc[WIDTH-1:0];
      fix_hi = neg_rem ? -eng_acc[2*WIDTH-1:WIDTH] : eng_acc[2*WIDTH-1:WIDTH];
    end else begin
      {fix_hi, fix_lo} = neg_res ? -eng_acc : eng_acc;
    end
  end

  // control FSM with registered busy/done and HI/LO writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div_q <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (launch) begin
            is_div_q <= func[1];
            neg_res  <= sign_a ^ sign_b;
            neg_rem  <= func[1] && sign_a;
            if (div_zero) begin
              hi    <= a;
              lo    <= '1;
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        S_RUN: begin
          if (eng_last) state <= S_FIX;
        end
        S_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_mc.sv
// tb/tb_alu_control_mc.sv - directed self-checking bench for alu_control_mc
module tb_alu_control_mc;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  ALUop;
  logic [5:0]  func;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  operation;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  alu_control_mc #(.WIDTH(32), .OPW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ALUop     (ALUop),
    .func      (func),
    .a         (a),
    .b         (b),
    .operation (operation),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive a mul/div launch during cycle 0; returns at cycle 1
  task automatic launch(input logic [5:0] f, input logic [31:0] aa, input logic [31:0] bb);
    start = 1'b1;
    ALUop = 3'b010;
    func  = f;
    a     = aa;
    b     = bb;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%h want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%h want=0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h want=0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h want=0", lo); end
  endtask

  task automatic test_decode();
    logic [12:0] vec [25];
    vec = '{
      {3'b000, 6'b000000, 4'h2}, {3'b001, 6'b000000, 4'h6}, {3'b011, 6'b000000, 4'h0},
      {3'b100, 6'b000000, 4'h1}, {3'b101, 6'b000000, 4'h7}, {3'b110, 6'b000000, 4'h3},
      {3'b111, 6'b000000, 4'h0}, {3'b010, 6'b100000, 4'h2}, {3'b010, 6'b100001, 4'h2},
      {3'b010, 6'b100010, 4'h6}, {3'b010, 6'b100011, 4'h6}, {3'b010, 6'b100100, 4'h0},
      {3'b010, 6'b100101, 4'h1}, {3'b010, 6'b100110, 4'h3}, {3'b010, 6'b100111, 4'hC},
      {3'b010, 6'b101010, 4'h7}, {3'b010, 6'b000000, 4'h8}, {3'b010, 6'b000010, 4'h9},
      {3'b010, 6'b000011, 4'hA}, {3'b010, 6'b011000, 4'hF}, {3'b010, 6'b011001, 4'hF},
      {3'b010, 6'b011010, 4'hF}, {3'b010, 6'b011011, 4'hF}, {3'b010, 6'b111111, 4'h0},
      {3'b000, 6'b011000, 4'h2}
    };
    for (int i = 0; i < 25; i++) begin
      ALUop = vec[i][12:10];
      func  = vec[i][9:4];
      #1;
      checks++;
      if (operation !== vec[i][3:0]) begin
        errors++;
        $display("FAIL decode aluop=%b func=%b got=%h want=%h", ALUop, func, operation, vec[i][3:0]);
      end
    end
    ALUop = 3'b000;
    func  = 6'b000000;
    tick();
  endtask

  task automatic test_multu();
    launch(6'b011001, 32'hFFFFFFFF, 32'h00000002);
    for (int c = 1; c <= 34; c++) begin
      checks++;
      if (busy !== (c <= 33)) begin errors++; $display("FAIL multu_busy cycle=%0d got=%b want=%b", c, busy, (c <= 33)); end
      checks++;
      if (done !== (c == 34)) begin errors++; $display("FAIL multu_done cycle=%0d got=%b want=%b", c, done, (c == 34)); end
      if (c == 34) begin
        checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL multu_hi got=%h want=00000001", hi); end
        checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo got=%h want=FFFFFFFE", lo); end
      end else if (c < 33) begin
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL multu_hi_early cycle=%0d got=%h want=0", c, hi); end
      end
      tick();
    end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_mult();
    int dc;
    dc = -1;
    launch(6'b011000, 32'hFFFFFFFD, 32'h00000007);
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      if (done === 1'b1) dc = c;
      else tick();
    end
    checks++; if (dc != 34) begin errors++; $display("FAIL mult_done_cycle got=%0d want=34", dc); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h want=FFFFFFFF", hi); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got=%h want=FFFFFFEB", lo); end
    tick();
  endtask

  task automatic test_back_to_back();
    int dc;
    dc = -1;
    launch(6'b011010, 32'hFFFFFFF9, 32'h00000002);
    for (int c = 1; c < 34; c++) tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL div1_done got=%b want=1", done); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div1_lo got=%h want=FFFFFFFD", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div1_hi got=%h want=FFFFFFFF", hi); end
    launch(6'b011010, 32'h80000000, 32'hFFFFFFFF);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b want=1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done got=%b want=0", done); end
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      if (done === 1'b1) dc = c;
      else tick();
    end
    checks++; if (dc != 34) begin errors++; $display("FAIL div2_done_cycle got=%0d want=34", dc); end
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div2_lo got=%h want=80000000", lo); end
    checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL div2_hi got=%h want=00000000", hi); end
    tick();
  endtask

  task automatic test_div_zero();
    launch(6'b011011, 32'h12345678, 32'h00000000);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL dz_done got=%b want=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_busy got=%b want=0", busy); end
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL dz_hi got=%h want=12345678", hi); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_lo got=%h want=FFFFFFFF", lo); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL dz_done_end got=%b want=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_reset_abort();
    int seen_done;
    seen_done = 0;
    launch(6'b011000, 32'h00000005, 32'h00000003);
    for (int c = 1; c < 5; c++) tick();
    start = 1'b1;
    ALUop = 3'b010;
    func  = 6'b011011;
    a     = 32'hDEADBEEF;
    b     = 32'h0;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got=%b want=1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ignore_done got=%b want=0", done); end
    checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL ignore_hi got=%h want=12345678", hi); end
    for (int c = 6; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL abort_hi got=%h want=0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL abort_lo got=%h want=0", lo); end
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done = 1;
      tick();
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL abort_no_done got=%0d want=0", seen_done); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ALUop = 3'b000;
    func  = 6'b000000;
    a     = 32'h0;
    b     = 32'h0;
    #1;
    test_reset();
    test_decode();
    test_multu();
    test_mult();
    test_back_to_back();
    test_div_zero();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
